// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
//   Shared decode/control definitions for the ID/EX stage and its hazard
//   detector: ALUOp and Jump encodings, MIPS opcode/funct constants, the
//   packed control word carried from decode into execute, and the bubble
//   control word.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_SUBU = 4'b1011;
    localparam logic [3:0] ALU_BGTZ = 4'b1100;
    localparam logic [3:0] ALU_BGEZ = 4'b1101;
    localparam logic [3:0] ALU_BNE  = 4'b1110;

    localparam logic [1:0] JUMP_NONE   = 2'b00;
    localparam logic [1:0] JUMP_JR     = 2'b01;
    localparam logic [1:0] JUMP_JR_FWD = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef struct packed {
        logic       RegWrite;
        logic       MemToReg;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       RegDst;
        logic       ALUSrc;
        logic [3:0] ALUOp;
        logic [1:0] Jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use.sv
// load_use_detect
//   Combinational load-use hazard detector. Flags when the load sitting in
//   EX writes a register that the instruction in decode reads this cycle.
//   Ports:
//     i_ex_valid, i_ex_mem_read, i_ex_write_reg : the instruction in EX
//     i_id_valid, i_id_rs, i_id_rt, i_id_alu_src : the instruction in decode
//     i_hold, i_flush                            : stage-level overrides
//     o_load_use_stall                           : hold IF/ID and PC this cycle
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_write_reg,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_alu_src,
    input  logic              i_hold,
    input  logic              i_flush,
    output logic              o_load_use_stall
);

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_in_ex;

    // rt is only a source when the second ALU operand is not the immediate.
    assign w_rs_hit     = (i_ex_write_reg == i_id_rs);
    assign w_rt_hit     = (i_ex_write_reg == i_id_rt) & ~i_id_alu_src;
    assign w_load_in_ex = i_ex_valid & i_ex_mem_read & (|i_ex_write_reg);

    // Under hold the frozen pair is re-evaluated after release; under flush
    // the decode instruction is being squashed anyway.
    assign o_load_use_stall = w_load_in_ex & i_id_valid & (w_rs_hit | w_rt_hit)
                            & ~i_hold & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of the 5-stage MIPS core. Captures the decode
//   control word, register-file read data, immediate, PC+4 and register
//   indices for execute, inserts a bubble on flush or load-use hazard, and
//   returns the EX destination register to decode for JR forwarding.
//   Ports:
//     clk, reset (sync, active-high), flush, hold
//     id_*           : decode-side instruction fields and control bits
//     ex_*           : registered copies, 1-cycle latency
//     ex_valid       : EX holds a real instruction
//     ex_write_reg   : EX destination (RegDst=1 selects rt)
//     load_use_stall : combinational, freezes IF/ID and PC
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              id_RegWrite,
    input  logic              id_MemToReg,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic              id_RegDst,
    input  logic              id_ALUSrc,
    input  logic [3:0]        id_ALUOp,
    input  logic [1:0]        id_Jump,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [4:0]        ex_shamt,
    output logic              ex_RegWrite,
    output logic              ex_MemToReg,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic [3:0]        ex_ALUOp,
    output logic [1:0]        ex_Jump,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic              load_use_stall
);

    ctrl_t             w_id_ctrl;
    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [4:0]        r_shamt;
    logic [REG_AW-1:0] w_write_reg;
    logic              w_load_use_stall;
    logic              w_bubble;

    assign w_id_ctrl = '{RegWrite: id_RegWrite, MemToReg: id_MemToReg,
                         MemRead:  id_MemRead,  MemWrite: id_MemWrite,
                         Branch:   id_Branch,   RegDst:   id_RegDst,
                         ALUSrc:   id_ALUSrc,   ALUOp:    id_ALUOp,
                         Jump:     id_Jump};

    assign w_write_reg = r_ctrl.RegDst ? r_rt : r_rd;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use (
        .i_ex_valid       (r_valid),
        .i_ex_mem_read    (r_ctrl.MemRead),
        .i_ex_write_reg   (w_write_reg),
        .i_id_valid       (id_valid),
        .i_id_rs          (id_rs),
        .i_id_rt          (id_rt),
        .i_id_alu_src     (id_ALUSrc),
        .i_hold           (hold),
        .i_flush          (flush),
        .o_load_use_stall (w_load_use_stall)
    );

    // The detector already masks the stall under hold, so flush and reset
    // are the only bubble sources that can override a hold.
    assign w_bubble = reset | flush | w_load_use_stall;

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_ctrl    <= CTRL_BUBBLE;
            r_valid   <= 1'b0;
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_shamt   <= '0;
        end else if (!hold) begin
            // Data is captured even for an invalid slot; only control is killed.
            r_ctrl    <= id_valid ? w_id_ctrl : CTRL_BUBBLE;
            r_valid   <= id_valid;
            r_pc4     <= id_pc4;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            r_shamt   <= id_shamt;
        end
    end

    assign ex_pc4         = r_pc4;
    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm         = r_imm;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_rd          = r_rd;
    assign ex_shamt       = r_shamt;
    assign ex_RegWrite    = r_ctrl.RegWrite;
    assign ex_MemToReg    = r_ctrl.MemToReg;
    assign ex_MemRead     = r_ctrl.MemRead;
    assign ex_MemWrite    = r_ctrl.MemWrite;
    assign ex_Branch      = r_ctrl.Branch;
    assign ex_RegDst      = r_ctrl.RegDst;
    assign ex_ALUSrc      = r_ctrl.ALUSrc;
    assign ex_ALUOp       = r_ctrl.ALUOp;
    assign ex_Jump        = r_ctrl.Jump;
    assign ex_valid       = r_valid;
    assign ex_write_reg   = w_write_reg;
    assign load_use_stall = w_load_use_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed-vector bench for id_ex_stage. The driver applies one vector per
//   cycle just after the rising edge and queues two expectations: the
//   combinational stall for this cycle and the EX-stage contents after the
//   next edge. A monitor on the falling edge pops and compares them.
module tb_id_ex_stage;

    localparam int CAP = 0;
    localparam int BUB = 1;
    localparam int HLD = 2;

    typedef struct packed {
        logic        v;
        logic [12:0] ctrl;
        logic [4:0]  wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        hd;
        logic        valid;
        logic [12:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } in_t;

    typedef struct {
        int    cyc;
        int    kind;
        string nm;
        logic  es;
        obs_t  eo;
    } item_t;

    // ctrl bit order: RegWrite MemToReg MemRead MemWrite Branch RegDst ALUSrc ALUOp[4] Jump[2]
    localparam logic [12:0] CTL_ADD  = 13'b1_0_0_0_0_0_0_0001_00;
    localparam logic [12:0] CTL_ADDI = 13'b1_0_0_0_0_1_1_0001_00;
    localparam logic [12:0] CTL_LW   = 13'b1_1_1_0_0_1_1_0001_00;
    localparam logic [12:0] CTL_JR   = 13'b0_0_0_0_0_0_0_0000_10;

    logic        clk = 1'b0;
    logic        reset, flush, hold, id_valid;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst, id_ALUSrc;
    logic [3:0]  id_ALUOp;
    logic [1:0]  id_Jump;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_write_reg;
    logic        ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegDst, ex_ALUSrc;
    logic [3:0]  ex_ALUOp;
    logic [1:0]  ex_Jump;
    logic        ex_valid, load_use_stall;

    obs_t  w_obs;
    obs_t  r_model;
    item_t sb[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    logic  end_req = 1'b0;
    logic  end_ack = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_RegWrite(id_RegWrite), .id_MemToReg(id_MemToReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_RegDst(id_RegDst),
        .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp), .id_Jump(id_Jump),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_RegDst(ex_RegDst),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_Jump(ex_Jump),
        .ex_valid(ex_valid), .ex_write_reg(ex_write_reg), .load_use_stall(load_use_stall)
    );

    assign w_obs = {ex_valid, ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch,
                    ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Jump, ex_write_reg, ex_rs, ex_rt,
                    ex_rd, ex_shamt, ex_pc4, ex_rs_data, ex_rt_data, ex_imm};

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        item_t it;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            total = total + 1;
            if (it.kind == 0) begin
                if (load_use_stall !== it.es) begin
                    bad = bad + 1;
                    $display("FAIL %s stall: got %b want %b", it.nm, load_use_stall, it.es);
                end
            end else if (w_obs !== it.eo) begin
                bad = bad + 1;
                $display("FAIL %s ex state: got %h want %h", it.nm, w_obs, it.eo);
            end
        end
        if (end_req && !end_ack) begin
            total = total + 1;
            if (sb.size() != 0) begin
                bad = bad + 1;
                $display("FAIL drain: got %0d pending want 0", sb.size());
            end
            end_ack = 1'b1;
        end
    end

    function automatic in_t mk(int n, logic rst, logic fl, logic hd, logic vld,
                               logic [12:0] ctl, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        in_t x;
        x.rst = rst; x.fl = fl; x.hd = hd; x.valid = vld; x.ctrl = ctl;
        x.rs = rs; x.rt = rt; x.rd = rd;
        x.sh  = 5'(n + 3);
        x.pc4 = 32'h0040_0000 + 32'(n * 4);
        x.a   = 32'hA500_0000 | 32'(n);
        x.b   = 32'hB600_0000 | 32'(n);
        x.imm = 32'hFFFF_8000 | 32'(n);
        return x;
    endfunction

    task automatic apply(input string nm, input in_t x, input logic exp_stall, input int act);
        item_t it;
        obs_t  e;
        @(posedge clk);
        #1;
        reset = x.rst; flush = x.fl; hold = x.hd; id_valid = x.valid;
        {id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst,
         id_ALUSrc, id_ALUOp, id_Jump} = x.ctrl;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_shamt = x.sh;
        id_pc4 = x.pc4; id_rs_data = x.a; id_rt_data = x.b; id_imm = x.imm;
        if (act == BUB) begin
            e = '0;
        end else if (act == HLD) begin
            e = r_model;
        end else begin
            e.v    = x.valid;
            e.ctrl = x.valid ? x.ctrl : 13'd0;
            e.wr   = e.ctrl[7] ? x.rt : x.rd;
            e.rs = x.rs; e.rt = x.rt; e.rd = x.rd; e.sh = x.sh;
            e.pc4 = x.pc4; e.a = x.a; e.b = x.b; e.imm = x.imm;
        end
        r_model = e;
        it.cyc = cyc;     it.kind = 0; it.nm = nm; it.es = exp_stall; it.eo = '0;
        sb.push_back(it);
        it.cyc = cyc + 1; it.kind = 1; it.eo = e;
        sb.push_back(it);
    endtask

    initial begin
        in_t r;
        reset = 1'b1; flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
        {id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst,
         id_ALUSrc, id_ALUOp, id_Jump} = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
        id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        r_model = '0;

        for (int i = 0; i < 2; i++) begin
            r = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            r.rst = 1'b1; r.fl = 1'b0; r.hd = 1'b0;
            apply("reset", r, 1'b0, BUB);
        end
        apply("add",       mk(1, 0,0,0,1, CTL_ADD,  5'd3, 5'd4, 5'd5),  1'b0, CAP);
        apply("addi",      mk(2, 0,0,0,1, CTL_ADDI, 5'd2, 5'd7, 5'd0),  1'b0, CAP);
        apply("lw8",       mk(3, 0,0,0,1, CTL_LW,   5'd1, 5'd8, 5'd0),  1'b0, CAP);
        apply("use_rs",    mk(4, 0,0,0,1, CTL_ADD,  5'd8, 5'd2, 5'd10), 1'b1, BUB);
        apply("use_rs_re", mk(4, 0,0,0,1, CTL_ADD,  5'd8, 5'd2, 5'd10), 1'b0, CAP);
        apply("lw8b",      mk(5, 0,0,0,1, CTL_LW,   5'd1, 5'd8, 5'd0),  1'b0, CAP);
        apply("rt_imm",    mk(6, 0,0,0,1, CTL_ADDI, 5'd3, 5'd8, 5'd0),  1'b0, CAP);
        apply("lw8c",      mk(7, 0,0,0,1, CTL_LW,   5'd1, 5'd8, 5'd0),  1'b0, CAP);
        apply("use_rt",    mk(8, 0,0,0,1, CTL_ADD,  5'd1, 5'd8, 5'd11), 1'b1, BUB);
        apply("use_rt_re", mk(8, 0,0,0,1, CTL_ADD,  5'd1, 5'd8, 5'd11), 1'b0, CAP);
        apply("lw8d",      mk(9, 0,0,0,1, CTL_LW,   5'd1, 5'd8, 5'd0),  1'b0, CAP);
        apply("use_both",  mk(10,0,0,0,1, CTL_ADD,  5'd8, 5'd8, 5'd12), 1'b1, BUB);
        apply("both_re",   mk(10,0,0,0,1, CTL_ADD,  5'd8, 5'd8, 5'd12), 1'b0, CAP);
        apply("lw0",       mk(11,0,0,0,1, CTL_LW,   5'd1, 5'd0, 5'd0),  1'b0, CAP);
        apply("use_zero",  mk(12,0,0,0,1, CTL_ADD,  5'd0, 5'd0, 5'd13), 1'b0, CAP);
        apply("lw12",      mk(13,0,0,0,1, CTL_LW,   5'd2, 5'd12, 5'd0), 1'b0, CAP);
        for (int i = 0; i < 3; i++)
            apply("hold",  mk(14+i,0,0,1,1, CTL_ADD, 5'd12, 5'd4, 5'd6), 1'b0, HLD);
        apply("flush_hold",mk(17,0,1,1,1, CTL_ADD,  5'd12, 5'd4, 5'd6), 1'b0, BUB);
        apply("lw13",      mk(18,0,0,0,1, CTL_LW,   5'd2, 5'd13, 5'd0), 1'b0, CAP);
        apply("flush_haz", mk(19,0,1,0,1, CTL_ADD,  5'd13, 5'd4, 5'd6), 1'b0, BUB);
        apply("lw14",      mk(20,0,0,0,1, CTL_LW,   5'd2, 5'd14, 5'd0), 1'b0, CAP);
        apply("invalid",   mk(21,0,0,0,0, CTL_ADDI, 5'd14, 5'd14, 5'd6),1'b0, CAP);
        apply("add9",      mk(22,0,0,0,1, CTL_ADD,  5'd3, 5'd4, 5'd9),  1'b0, CAP);
        apply("jr9",       mk(23,0,0,0,1, CTL_JR,   5'd9, 5'd0, 5'd0),  1'b0, CAP);
        apply("lw15",      mk(24,0,0,0,1, CTL_LW,   5'd2, 5'd15, 5'd0), 1'b0, CAP);
        apply("hold15",    mk(25,0,0,1,1, CTL_ADD,  5'd15, 5'd4, 5'd6), 1'b0, HLD);
        apply("rst_hold",  mk(26,1,0,1,1, CTL_ADD,  5'd15, 5'd4, 5'd6), 1'b0, BUB);
        apply("after_rh",  mk(27,0,0,0,1, CTL_ADD,  5'd15, 5'd4, 5'd6), 1'b0, CAP);
        apply("lw16",      mk(28,0,0,0,1, CTL_LW,   5'd2, 5'd16, 5'd0), 1'b0, CAP);
        apply("rst_stall", mk(29,1,0,0,1, CTL_ADD,  5'd16, 5'd4, 5'd6), 1'b1, BUB);
        apply("after_rs",  mk(30,0,0,0,1, CTL_ADD,  5'd16, 5'd4, 5'd6), 1'b0, CAP);
        apply("idle",      mk(31,0,0,0,0, 13'd0,    5'd0, 5'd0, 5'd0),  1'b0, CAP);

        repeat (2) @(posedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) @(posedge clk);
        if (!end_ack) begin
            bad = bad + 1;
            $display("FAIL monitor: got no drain ack want ack");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
